// File: rtl/datapath_sequencer_if.sv
// Command and datapath-control bundle for the datapath sequencer.
// The slave modport is the sequencer's view; the master modport is the
// environment that issues commands and returns ALU flags.
interface datapath_sequencer_if;
    // Command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_sel;
    logic [4:0]  cmd_srcA;
    logic [4:0]  cmd_srcB;
    logic [4:0]  cmd_dst;
    logic        cmd_cin;
    logic        cmd_muxSel;
    logic [1:0]  cmd_wb;

    // Datapath controls
    logic [4:0]  readA;
    logic [4:0]  readB;
    logic [4:0]  writeReg;
    logic [4:0]  sel;
    logic        cin;
    logic        muxSel;
    logic        write;
    logic        writeRam;

    // ALU flags returned by the datapath
    logic [3:0]  status;
    logic        Cout;

    // Completion reporting
    logic        done;
    logic [3:0]  done_status;
    logic        done_cout;
    logic [15:0] op_count;

    modport slave (
        input  cmd_valid, cmd_sel, cmd_srcA, cmd_srcB, cmd_dst,
               cmd_cin, cmd_muxSel, cmd_wb, status, Cout,
        output cmd_ready, readA, readB, writeReg, sel, cin, muxSel,
               write, writeRam, done, done_status, done_cout, op_count
    );

    modport master (
        output cmd_valid, cmd_sel, cmd_srcA, cmd_srcB, cmd_dst,
               cmd_cin, cmd_muxSel, cmd_wb, status, Cout,
        input  cmd_ready, readA, readB, writeReg, sel, cin, muxSel,
               write, writeRam, done, done_status, done_cout, op_count
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Datapath sequencer: accepts one command at a time and walks it through
// READ -> EXEC -> (WB) -> DONE, driving registered datapath controls,
// capturing ALU flags at the end of EXEC and counting completed commands.
module datapath_sequencer (
    input  logic                 clock,
    input  logic                 reset,
    datapath_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } stateT;

    stateT       state_q;

    // Latched command fields that are not themselves visible as outputs
    logic [4:0]  cmdDst_q;
    logic [1:0]  cmdWb_q;

    // Registered outputs; readA/readB/sel/cin/muxSel double as the latch
    // for the corresponding command fields while a command is in flight.
    logic        cmdReady_q;
    logic [4:0]  readA_q;
    logic [4:0]  readB_q;
    logic [4:0]  writeReg_q;
    logic [4:0]  sel_q;
    logic        cin_q;
    logic        muxSel_q;
    logic        write_q;
    logic        writeRam_q;
    logic        done_q;
    logic [3:0]  doneStatus_q;
    logic        doneCout_q;
    logic [15:0] opCount_q;

    // Sequencer FSM: state plus every output is computed for the next cycle here
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cmdDst_q     <= 5'd0;
            cmdWb_q      <= 2'd0;
            cmdReady_q   <= 1'b1;
            readA_q      <= 5'd0;
            readB_q      <= 5'd0;
            writeReg_q   <= 5'd0;
            sel_q        <= 5'd0;
            cin_q        <= 1'b0;
            muxSel_q     <= 1'b0;
            write_q      <= 1'b0;
            writeRam_q   <= 1'b0;
            done_q       <= 1'b0;
            doneStatus_q <= 4'd0;
            doneCout_q   <= 1'b0;
            opCount_q    <= 16'd0;
        end else begin
            write_q    <= 1'b0;
            writeRam_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmdReady_q) begin
                        state_q    <= READ;
                        cmdReady_q <= 1'b0;
                        readA_q    <= bus.cmd_srcA;
                        readB_q    <= bus.cmd_srcB;
                        sel_q      <= bus.cmd_sel;
                        cin_q      <= bus.cmd_cin;
                        muxSel_q   <= bus.cmd_muxSel;
                        cmdDst_q   <= bus.cmd_dst;
                        cmdWb_q    <= bus.cmd_wb;
                    end
                end
                READ: begin
                    state_q <= EXEC;
                end
                EXEC: begin
                    doneStatus_q <= bus.status;
                    doneCout_q   <= bus.Cout;
                    if (cmdWb_q != 2'b00) begin
                        state_q    <= WB;
                        writeReg_q <= cmdDst_q;
                        write_q    <= cmdWb_q[0];
                        writeRam_q <= cmdWb_q[1];
                    end else begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        opCount_q <= opCount_q + 16'd1;
                    end
                end
                WB: begin
                    state_q   <= DONE;
                    done_q    <= 1'b1;
                    opCount_q <= opCount_q + 16'd1;
                end
                DONE: begin
                    state_q    <= IDLE;
                    cmdReady_q <= 1'b1;
                    readA_q    <= 5'd0;
                    readB_q    <= 5'd0;
                    sel_q      <= 5'd0;
                    cin_q      <= 1'b0;
                    muxSel_q   <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    cmdReady_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmdReady_q;
    assign bus.readA       = readA_q;
    assign bus.readB       = readB_q;
    assign bus.writeReg    = writeReg_q;
    assign bus.sel         = sel_q;
    assign bus.cin         = cin_q;
    assign bus.muxSel      = muxSel_q;
    assign bus.write       = write_q;
    assign bus.writeRam    = writeRam_q;
    assign bus.done        = done_q;
    assign bus.done_status = doneStatus_q;
    assign bus.done_cout   = doneCout_q;
    assign bus.op_count    = opCount_q;

endmodule
